// File: rtl/ram_pkg.sv
// ram_pkg
//   Shared definitions for the multi-read-port RAM slice.
//   - RUW_READ_FIRST / RUW_WRITE_FIRST: read-under-write selector values.
//   - seq_state_t: clear sequencer states.
//   - lane_merge(): per-lane select of new over old data. It is shared by the
//     array write path and the write-first forward path, so both produce the
//     same merged word.
package ram_pkg;

   localparam int RUW_READ_FIRST  = 0;
   localparam int RUW_WRITE_FIRST = 1;

   // Widest word / mask the merge helper handles. Callers zero-extend into
   // these widths and truncate the result back.
   localparam int MAX_WORD_WIDTH = 512;
   localparam int MAX_MASK_WIDTH = 64;

   typedef enum logic {
      SEQ_CLEAR = 1'b0,
      SEQ_RUN   = 1'b1
   } seq_state_t;

   // Bit i takes new_word when its lane (i / lane_width) is enabled in mask.
   function automatic logic [MAX_WORD_WIDTH-1:0] lane_merge(
      input logic [MAX_WORD_WIDTH-1:0] old_word,
      input logic [MAX_WORD_WIDTH-1:0] new_word,
      input logic [MAX_MASK_WIDTH-1:0] mask,
      input int                        lane_width
   );
      logic [MAX_WORD_WIDTH-1:0] merged;
      int                        lane;
      merged = old_word;
      for (int i = 0; i < MAX_WORD_WIDTH; i++) begin
         lane = i / lane_width;
         if (lane < MAX_MASK_WIDTH) begin
            if (mask[lane[5:0]]) begin
               merged[i] = new_word[i];
            end
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/ram_read_port.sv
// ram_read_port
//   One read pipe: accept, read-under-write forwarding, 1- or 2-stage latency
//   and hold.
//   clk, reset  : clock and asynchronous active-high reset
//   run         : sequencer is in RUN (reads allowed)
//   rd_en       : read request for this port
//   rd_hold     : freeze every stage of this port
//   mem_word    : array word at this port's address (zero when out of range)
//   wr_hit      : a write lands on this port's address on this edge
//   wr_data     : write data (for forwarding)
//   wr_mask     : write lane enables (for forwarding)
//   rd_data     : read result
//   rd_valid    : rd_data carries a fresh result
module ram_read_port
   import ram_pkg::*;
#(
   parameter int WORD_WIDTH  = 64,
   parameter int MASK_WIDTH  = 8,
   parameter int RD_LATENCY  = 1,
   parameter int WRITE_FIRST = RUW_READ_FIRST
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  run,
   input  logic                  rd_en,
   input  logic                  rd_hold,
   input  logic [WORD_WIDTH-1:0] mem_word,
   input  logic                  wr_hit,
   input  logic [WORD_WIDTH-1:0] wr_data,
   input  logic [MASK_WIDTH-1:0] wr_mask,
   output logic [WORD_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);

   localparam int LANE_WIDTH = WORD_WIDTH / MASK_WIDTH;

   logic                  accept;
   logic [WORD_WIDTH-1:0] fwd_word;
   logic [WORD_WIDTH-1:0] snap_word;
   logic                  s1_valid_reg;
   logic [WORD_WIDTH-1:0] s1_data_reg;

   assign accept = run & rd_en & ~rd_hold;

   // Write-first: lanes being written on this edge come from wr_data.
   assign fwd_word = wr_hit
      ? WORD_WIDTH'(lane_merge(MAX_WORD_WIDTH'(mem_word), MAX_WORD_WIDTH'(wr_data),
                               MAX_MASK_WIDTH'(wr_mask), LANE_WIDTH))
      : mem_word;

   assign snap_word = (WRITE_FIRST == RUW_WRITE_FIRST) ? fwd_word : mem_word;

   // Stage 1 captures the snapshot at the accept edge; a non-accepted,
   // non-held cycle pushes a bubble and leaves the data untouched.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_reg <= 1'b0;
         s1_data_reg  <= '0;
      end else if (!rd_hold) begin
         s1_valid_reg <= accept;
         if (accept) begin
            s1_data_reg <= snap_word;
         end
      end
   end

   if (RD_LATENCY == 2) begin : g_lat2
      logic                  s2_valid_reg;
      logic [WORD_WIDTH-1:0] s2_data_reg;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            s2_valid_reg <= 1'b0;
            s2_data_reg  <= '0;
         end else if (!rd_hold) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
               s2_data_reg <= s1_data_reg;
            end
         end
      end

      assign rd_valid = s2_valid_reg;
      assign rd_data  = s2_data_reg;
   end else begin : g_lat1
      assign rd_valid = s1_valid_reg;
      assign rd_data  = s1_data_reg;
   end

endmodule

// File: rtl/ram_1w_nr_sync.sv
// ram_1w_nr_sync
//   Single-clock RAM: one byte-masked write port, READ_PORTS synchronous read
//   ports, optional post-reset clear of the whole array.
//   clk, reset : clock and asynchronous active-high reset
//   init_busy  : clear sequencer running; traffic is ignored meanwhile
//   wr_en, wr_mask, wr_addr, wr_data : write request
//   rd_en, rd_hold : per-port request and pipeline freeze
//   rd_addr    : port p address at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   rd_data    : port p data at [p*WORD_WIDTH +: WORD_WIDTH]
//   rd_valid   : per-port fresh-result flag
module ram_1w_nr_sync
   import ram_pkg::*;
#(
   parameter  int WORD_COUNT     = 512,
   parameter  int WORD_WIDTH     = 64,
   parameter  int MASK_WIDTH     = 8,
   parameter  int READ_PORTS     = 2,
   parameter  int RD_LATENCY     = 1,
   parameter  int WRITE_FIRST    = RUW_READ_FIRST,
   parameter  int CLEAR_ON_RESET = 1,
   localparam int ADDR_WIDTH     = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   output logic                             init_busy,
   input  logic                             wr_en,
   input  logic [MASK_WIDTH-1:0]            wr_mask,
   input  logic [ADDR_WIDTH-1:0]            wr_addr,
   input  logic [WORD_WIDTH-1:0]            wr_data,
   input  logic [READ_PORTS-1:0]            rd_en,
   input  logic [READ_PORTS-1:0]            rd_hold,
   input  logic [READ_PORTS*ADDR_WIDTH-1:0] rd_addr,
   output logic [READ_PORTS*WORD_WIDTH-1:0] rd_data,
   output logic [READ_PORTS-1:0]            rd_valid
);

   localparam int                    LANE_WIDTH = WORD_WIDTH / MASK_WIDTH;
   localparam bit                    FULL_RANGE = (WORD_COUNT == (1 << ADDR_WIDTH));
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(WORD_COUNT - 1);

   // Parameter legality, rejected at elaboration.
   if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
      $error("ram_1w_nr_sync: RD_LATENCY must be 1 or 2");
   end
   if (MASK_WIDTH < 1 || (WORD_WIDTH % MASK_WIDTH) != 0) begin : g_bad_mask
      $error("ram_1w_nr_sync: MASK_WIDTH must divide WORD_WIDTH");
   end
   if (READ_PORTS < 1 || READ_PORTS > 4) begin : g_bad_ports
      $error("ram_1w_nr_sync: READ_PORTS must be 1..4");
   end
   if (WRITE_FIRST != RUW_READ_FIRST && WRITE_FIRST != RUW_WRITE_FIRST) begin : g_bad_ruw
      $error("ram_1w_nr_sync: WRITE_FIRST must be 0 or 1");
   end
   if (WORD_WIDTH > MAX_WORD_WIDTH || MASK_WIDTH > MAX_MASK_WIDTH) begin : g_bad_width
      $error("ram_1w_nr_sync: word or mask wider than lane_merge supports");
   end

   seq_state_t            state_reg;
   logic [ADDR_WIDTH-1:0] cnt_reg;
   logic                  run;
   logic                  wr_in_range;
   logic                  wr_accept;
   logic [WORD_WIDTH-1:0] wr_merged;
   logic [WORD_WIDTH-1:0] mem [WORD_COUNT];

   // Clear sequencer: one zero write per cycle, WORD_COUNT cycles in total.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= (CLEAR_ON_RESET != 0) ? SEQ_CLEAR : SEQ_RUN;
         cnt_reg   <= '0;
      end else if (state_reg == SEQ_CLEAR) begin
         cnt_reg <= cnt_reg + 1'b1;
         if (cnt_reg == LAST_ADDR) begin
            state_reg <= SEQ_RUN;
         end
      end
   end

   assign run       = (state_reg == SEQ_RUN);
   assign init_busy = (state_reg == SEQ_CLEAR);

   if (FULL_RANGE) begin : g_wr_full
      assign wr_in_range = 1'b1;
   end else begin : g_wr_part
      assign wr_in_range = (wr_addr < ADDR_WIDTH'(WORD_COUNT));
   end

   assign wr_accept = run & wr_en & wr_in_range & (|wr_mask);

   assign wr_merged = WORD_WIDTH'(lane_merge(MAX_WORD_WIDTH'(mem[wr_addr]),
                                             MAX_WORD_WIDTH'(wr_data),
                                             MAX_MASK_WIDTH'(wr_mask), LANE_WIDTH));

   // The array has no flop reset; the sequencer owns the port while clearing.
   always_ff @(posedge clk) begin
      if (!run) begin
         mem[cnt_reg] <= '0;
      end else if (wr_accept) begin
         mem[wr_addr] <= wr_merged;
      end
   end

   genvar gi;
   for (gi = 0; gi < READ_PORTS; gi++) begin : g_port
      logic [ADDR_WIDTH-1:0] addr;
      logic                  in_range;
      logic [WORD_WIDTH-1:0] word;
      logic                  wr_hit;

      assign addr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];

      if (FULL_RANGE) begin : g_full
         assign in_range = 1'b1;
      end else begin : g_part
         assign in_range = (addr < ADDR_WIDTH'(WORD_COUNT));
      end

      // Out-of-range reads return zero and never see forwarding.
      assign word   = in_range ? mem[addr] : '0;
      assign wr_hit = wr_accept & in_range & (addr == wr_addr);

      ram_read_port #(
         .WORD_WIDTH  (WORD_WIDTH),
         .MASK_WIDTH  (MASK_WIDTH),
         .RD_LATENCY  (RD_LATENCY),
         .WRITE_FIRST (WRITE_FIRST)
      ) u_port (
         .clk      (clk),
         .reset    (reset),
         .run      (run),
         .rd_en    (rd_en[gi]),
         .rd_hold  (rd_hold[gi]),
         .mem_word (word),
         .wr_hit   (wr_hit),
         .wr_data  (wr_data),
         .wr_mask  (wr_mask),
         .rd_data  (rd_data[gi*WORD_WIDTH +: WORD_WIDTH]),
         .rd_valid (rd_valid[gi])
      );
   end

endmodule

// File: doc/ram_1w_nr_sync.md
Name: ram_1w_nr_sync

Overview:
- Single-clock memory with one byte-masked write port and READ_PORTS independent synchronous read ports.
- Read latency is configurable (1 or 2). Read-under-write is deterministic (read-first or write-first with per-lane forwarding). Each read port has a per-port hold.
- An optional clear sequencer zeroes the array after reset.
- Successor to the generic 1w/1r fallback RAM; used by SMP cache/tag generators that need several read ports and known reset contents.

Parameters:
- WORD_COUNT, 512: number of words.
- WORD_WIDTH, 64: bits per word.
- MASK_WIDTH, 8: write lanes; lane width = WORD_WIDTH/MASK_WIDTH, must divide exactly.
- READ_PORTS, 2: number of read ports, 1..4.
- RD_LATENCY, 1: cycles from accepted read to data; only 1 or 2 are legal.
- WRITE_FIRST, 0: 0 = read-first (old data); 1 = write-first (masked lanes forwarded).
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset before accepting traffic.
- ADDR_WIDTH, clog2(WORD_COUNT): derived, do not override.

Ports:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- init_busy  out  1  high while the clear sequencer runs.
- wr_en  in  1  write request.
- wr_mask  in  MASK_WIDTH  lane enables.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  WORD_WIDTH  write data.
- rd_en  in  READ_PORTS  per-port read request.
- rd_hold  in  READ_PORTS  per-port pipeline freeze.
- rd_addr  in  READ_PORTS*ADDR_WIDTH  port p at [p*ADDR_WIDTH +: ADDR_WIDTH].
- rd_data  out  READ_PORTS*WORD_WIDTH  port p at [p*WORD_WIDTH +: WORD_WIDTH].
- rd_valid  out  READ_PORTS  rd_data of port p carries a fresh result.

Behaviour:
- Reset (async assert): all rd_data=0, rd_valid=0, all pipeline registers cleared. init_busy=CLEAR_ON_RESET. Array contents are not reset by the flop reset itself.
- Sequencer states CLEAR and RUN.
  - Reset enters CLEAR with cnt=0 if CLEAR_ON_RESET, else RUN.
  - In CLEAR: each cycle write all-zero to mem[cnt], then cnt++. When cnt==WORD_COUNT-1 is written, go to RUN next cycle. CLEAR lasts exactly WORD_COUNT cycles after reset release.
  - Reset during CLEAR restarts at cnt=0.
  - In CLEAR, wr_en and rd_en are ignored, and rd_valid stays 0.
- Write (RUN): on clk with wr_en, each lane i with wr_mask[i]=1 is updated. Lanes with wr_mask[i]=0 keep their contents. wr_mask=0 is a no-op.
- Read accept: port p accepts when RUN & rd_en[p] & ~rd_hold[p]. The address is sampled on that edge.
- Read-under-write, same edge and same address:
  - WRITE_FIRST=0: returns the full old word.
  - WRITE_FIRST=1: masked lanes return wr_data; unmasked lanes return old contents.
- The returned value is a snapshot at the accept edge. For RD_LATENCY=2, a write in the following cycle is not forwarded.
- Latency:
  - RD_LATENCY=1: rd_data/rd_valid update on the accept edge, visible the next cycle.
  - RD_LATENCY=2: one extra register stage; data and valid advance together.
- Non-accepted cycle with rd_hold[p]=0: a bubble (valid=0) enters the pipe. At the pipe end rd_valid drops to 0 and rd_data keeps its last value (never forced to 0).
- rd_hold[p]=1: all stages of port p freeze, data and valid. Other ports are unaffected. An rd_en while held is dropped.
- Multiple ports may read the same address in the same cycle; each gets an identical result.
- Out-of-range address (WORD_COUNT not a power of two):
  - writes are dropped;
  - reads return all-zero with valid=1.
- Writes to an address, then reads of it on a later edge, always return the new data in both modes.
- Illegal RD_LATENCY or a MASK_WIDTH that does not divide WORD_WIDTH: elaboration-time error.

Decomposition:
- Package ram_pkg:
  - RUW_READ_FIRST=0 and RUW_WRITE_FIRST=1 constants;
  - seq_state_t enum {SEQ_CLEAR, SEQ_RUN};
  - lane-merge function (old, new, mask) used for both the write and the forward paths.
- Sub-module ram_read_port: one accept/forward/latency/hold pipe, instantiated READ_PORTS times by generate. The top owns the array, the write path and the sequencer.

Test Plan:
- Reset with CLEAR_ON_RESET=1, WORD_COUNT=16 -> init_busy high for exactly 16 cycles after release. Reads of all addresses then return 0 with valid=1. A write issued during busy is lost.
- Write 0x1122334455667788 to addr 5 with mask 0xFF, then mask 0x0F with data 0xAAAAAAAABBBBBBBB -> read returns 0x11223344BBBBBBBB.
- Same edge: write mask 0x01, data 0x..EE, to addr 5 plus port0 read of addr 5:
  - WRITE_FIRST=0 -> 0x11223344BBBBBBBB;
  - WRITE_FIRST=1 -> 0x11223344BBBBBBEE.
- RD_LATENCY=2, port0 reads addrs 1,2,3 back-to-back -> rd_valid high on cycles +2..+4 with the matching data. Port1 held for 2 cycles -> its output frozen while port0 streams unchanged.
- Assert reset mid-stream with valid=1 in flight -> rd_valid=0 and rd_data=0 immediately (async), and the sequencer restarts the clear from address 0.
- WORD_COUNT=12 -> read of addr 13 returns 0 with valid=1, and a write to addr 13 does not alias any addr 0..11.
